// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: presents one 48-bit round subkey per handshake,
// in encrypt (K1..K16) or decrypt (K16..K1) order, from a 64-bit key.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [55:0] kp_q, kp_d;
  logic        decrypt_q, decrypt_d;
  logic [27:0] c_half_q, c_half_d;
  logic [27:0] d_half_q, d_half_d;
  logic [3:0]  step_q, step_d;

  logic [55:0] key_pc1;
  logic [27:0] c_rot, d_rot;
  logic [55:0] cd_rot;
  logic [1:0]  rot_amt;
  logic [7:0]  parity_unused;

  function automatic logic [1:0] shift_of(input logic [4:0] j);
    return (j == 5'd1 || j == 5'd2 || j == 5'd9 || j == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Table entries are FIPS bit numbers, bit 1 being the MSB of each vector.
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign key_pc1[55-gi] = key[64-PC1_TAB[gi]];
    end
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign subkey[47-gi] = cd_rot[56-PC2_TAB[gi]];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
      assign parity_unused[gi] = key[8*gi];
    end
  endgenerate

  // Decrypt step 1 presents C0D0 unrotated; later steps undo the encrypt shifts.
  always_comb begin
    rot_amt = 2'd0;
    if (state_q == RUN) begin
      if (!decrypt_q) begin
        rot_amt = shift_of({1'b0, step_q} + 5'd1);
      end else if (step_q != 4'd0) begin
        rot_amt = shift_of(5'd17 - {1'b0, step_q});
      end
    end
    c_rot  = decrypt_q ? rotr28(c_half_q, rot_amt) : rotl28(c_half_q, rot_amt);
    d_rot  = decrypt_q ? rotr28(d_half_q, rot_amt) : rotl28(d_half_q, rot_amt);
    cd_rot = {c_rot, d_rot};
  end

  always_comb begin
    state_d   = state_q;
    kp_d      = kp_q;
    decrypt_d = decrypt_q;
    c_half_d  = c_half_q;
    d_half_d  = d_half_q;
    step_d    = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kp_d      = key_pc1;
          decrypt_d = decrypt;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        c_half_d = kp_q[55:28];
        d_half_d = kp_q[27:0];
        step_d   = 4'd0;
        state_d  = RUN;
      end
      RUN: begin
        if (subkey_ready) begin
          c_half_d = c_rot;
          d_half_d = d_rot;
          if (step_q == 4'd15) begin
            state_d = DONE;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kp_q      <= '0;
      decrypt_q <= 1'b0;
      c_half_q  <= '0;
      d_half_q  <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      kp_q      <= kp_d;
      decrypt_q <= decrypt_d;
      c_half_q  <= c_half_d;
      d_half_q  <= d_half_d;
      step_q    <= step_d;
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == LOAD) || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign round        = decrypt_q ? (4'd15 - step_q) : step_q;

endmodule
